bf_exec_ctrl: RTL and testbench
===============================

Name: bf_exec_ctrl

Overview:
- Execute-stage controller of the pipelined BF CPU; sits directly after the decode stage.
- Consumes one-hot decoded operations over the drdy/ack handshake.
- Owns the data pointer and the cached current cell, and sequences data-memory read/write, output/input handshakes and loop control.
- Loop control covers the bracket stack, forward skip on zero, and branch requests to fetch.

Parameters:
- DATA_W, 8, cell width.
- ADDR_W, 15, data-memory address width; pointer wraps modulo 2^ADDR_W.
- PC_W, 12, instruction address width.
- STACK_DEPTH, 16, loop-stack entries; power of two.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- operation  in  8  one-hot op: bit0 '>', bit1 '<', bit2 '+', bit3 '-', bit4 '.', bit5 ',', bit6 '[', bit7 ']'; 0 = NOP
- op_pc  in  PC_W  instruction address of operation
- drdy_in  in  1  operation/op_pc valid
- ack  out  1  one-cycle pulse: operation consumed
- dmem_addr  out  ADDR_W  data-memory address
- dmem_wdata  out  DATA_W  write data
- dmem_we  out  1  write enable
- dmem_rdata  in  DATA_W  synchronous read data, valid one cycle after address
- out_data  out  DATA_W  output byte
- out_valid  out  1  output request
- out_ready  in  1  output accepted
- in_data  in  DATA_W  input byte
- in_valid  in  1  input available
- in_ready  out  1  input request
- branch_pc  out  PC_W  fetch redirect target
- branch_valid  out  1  redirect request, held until branch_ack
- branch_ack  in  1  fetch has flushed and redirected
- error  out  1  sticky fault: stack overflow or underflow

Behaviour:
- Clocking: one clock, clk; reset is synchronous and active-high. All state updates on posedge clk.
- Reset values:
  - ack=0, dmem_we=0, out_valid=0, in_ready=0, branch_valid=0, error=0.
  - ptr=0, cell=0, sp=0, skip depth=0, state=EXEC.
  - Data memory is not cleared; cell 0 starts logically zero.
  - Reset mid-operation aborts any state immediately.
- Acceptance rule: an op is accepted only in EXEC/SKIP/BRANCH, with drdy_in=1 and ack=0. The ack=0 condition blocks double consumption while upstream still holds the old op. Throughput is at most 1 op per 2 cycles.
- ack is a registered pulse, high exactly one cycle, asserted the cycle after the op completes.
- States: EXEC, FETCH, LOAD, OUT, IN, SKIP, BRANCH, HALT.
- EXEC, per accepted op:
  - '+'/'-': cell <= cell ±1, modulo 2^DATA_W; ack next cycle.
  - '>'/'<': in the accept cycle, dmem_we=1, dmem_addr=ptr, dmem_wdata=cell (combinational). ptr <= ptr ±1 (wraps), then ->FETCH.
  - FETCH: dmem_addr=ptr, dmem_we=0, ->LOAD. LOAD: cell <= dmem_rdata, ack, ->EXEC. Move latency is 3 cycles from accept to ack.
  - '.': ->OUT. out_valid=1, out_data=cell held stable until out_ready. In the out_ready cycle, drop out_valid, ack, ->EXEC.
  - ',': ->IN. in_ready=1 until in_valid. Then cell <= in_data, ack, ->EXEC.
  - '[' with cell!=0: push op_pc; ack.
  - '[' with cell==0: depth <= 1, ack, ->SKIP.
  - '[' push with stack full: error=1, ->HALT, no ack.
  - ']' with cell==0: pop; ack. Pop with stack empty: error, HALT.
  - ']' with cell!=0 and stack empty: error, HALT.
  - ']' with cell!=0 and stack non-empty: branch_pc = top+1 (wraps in PC_W); branch_valid=1; ack; ->BRANCH. The stack is unchanged.
  - NOP, or more than one bit set in operation: ack, no effect.
- SKIP: every accepted op is acked and has no datapath effect.
  - '[' increments depth; ']' decrements depth.
  - When ']' takes depth 1->0, return to EXEC.
  - Skipped brackets never touch the stack.
- BRANCH: accepted ops are acked and discarded (stale pipeline contents). On branch_ack: branch_valid <= 0, ->EXEC. The next accepted op is the redirect target.
- HALT: no acks and no memory/IO activity; error stays 1 until reset.
- dmem_we is high only in the accept cycle of '>'/'<'.

Decomposition:
- Shared constants header defines: OPCODE_MSB, the op bit indices (OP_RIGHT..OP_LOOP_END), and the state encodings.
- One sub-module, bf_loop_stack (PC_W x STACK_DEPTH LIFO).
  - Ports: push, pop, din, top, empty, full; synchronous, reset clears sp.
  - Push or pop takes effect next edge; top is combinational from sp-1.

Test Plan:
- Reset, then '+' x3 then '.' (out_ready=1) -> out_data=3, out_valid 1 cycle, four ack pulses, no dmem_we.
- '-' from 0, then '.' -> out_data=8'hFF; '<' from ptr=0 -> dmem write addr 0 data FF, then read addr 7FFF (ptr wrap).
- '+' x5, '>', '+', '<', '.' -> write mem[0]=5, mem[1]=1; cell reloads 5; out_data=5. Each move acked 3 cycles after accept.
- ',' with in_valid delayed 4 cycles, in_data=8'h41 -> in_ready held 4 cycles, no ack until in_valid. Then '.' -> out_data=8'h41.
- cell=0, '[' at pc 10, then stream '[', '+', ']', ']', '.' -> first '+' and brackets acked without effect; SKIP exits after 2nd ']'. '.' outputs 0.
- cell=2, '[' at pc 4, '-', ']' -> branch_pc=5, branch_valid held until branch_ack; stale ops in BRANCH acked and discarded. The second ']' with cell=0 pops (sp back to 0). A 17th nested push -> error=1, HALT, no further acks.

Source files
------------

// File: rtl/bf_exec_ctrl_pkg.sv
// Shared constants for the BF execute-stage controller: opcode bit
// positions, FSM state encodings and the one-hot opcode decoder.
package bf_exec_ctrl_pkg;

  localparam int OPCODE_MSB  = 7;

  localparam int OP_RIGHT    = 0;
  localparam int OP_LEFT     = 1;
  localparam int OP_INC      = 2;
  localparam int OP_DEC      = 3;
  localparam int OP_OUT      = 4;
  localparam int OP_IN       = 5;
  localparam int OP_LOOP_BEG = 6;
  localparam int OP_LOOP_END = 7;

  typedef logic [OPCODE_MSB:0] opcode_t;

  localparam opcode_t OP_NONE = 8'h00;

  // Execute FSM encodings (all eight codes are used)
  localparam logic [2:0] ST_EXEC   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_LOAD   = 3'd2;
  localparam logic [2:0] ST_OUT    = 3'd3;
  localparam logic [2:0] ST_IN     = 3'd4;
  localparam logic [2:0] ST_SKIP   = 3'd5;
  localparam logic [2:0] ST_BRANCH = 3'd6;
  localparam logic [2:0] ST_HALT   = 3'd7;

  // Decoded operation; all fields zero for NOP or a malformed opcode
  typedef struct packed {
    logic lend;
    logic lbeg;
    logic get;
    logic put;
    logic dec;
    logic inc;
    logic left;
    logic right;
  } op_dec_t;

  // A valid op has exactly one bit set; anything else decodes to no-op
  function automatic op_dec_t decode_op(input opcode_t op);
    op_dec_t d;
    logic    one_hot;
    one_hot = (op != OP_NONE) && ((op & (op - opcode_t'(1))) == OP_NONE);
    d.right = one_hot & op[OP_RIGHT];
    d.left  = one_hot & op[OP_LEFT];
    d.inc   = one_hot & op[OP_INC];
    d.dec   = one_hot & op[OP_DEC];
    d.put   = one_hot & op[OP_OUT];
    d.get   = one_hot & op[OP_IN];
    d.lbeg  = one_hot & op[OP_LOOP_BEG];
    d.lend  = one_hot & op[OP_LOOP_END];
    return d;
  endfunction

endpackage

// File: rtl/bf_exec_ctrl_if.sv
// Bundle of the execute stage's decode, data-memory, I/O and fetch-redirect
// signals. master = the execute controller, slave = its environment.
interface bf_exec_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 15,
  parameter int PC_W   = 12
) ();

  // decode -> execute
  logic [7:0]        operation;
  logic [PC_W-1:0]   op_pc;
  logic              drdy_in;
  logic              ack;
  // data memory
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_rdata;
  // byte output
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  // byte input
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  // fetch redirect
  logic [PC_W-1:0]   branch_pc;
  logic              branch_valid;
  logic              branch_ack;
  // status
  logic              error;

  modport master (
    input  operation, op_pc, drdy_in, dmem_rdata, out_ready,
           in_data, in_valid, branch_ack,
    output ack, dmem_addr, dmem_wdata, dmem_we, out_data, out_valid,
           in_ready, branch_pc, branch_valid, error
  );

  modport slave (
    output operation, op_pc, drdy_in, dmem_rdata, out_ready,
           in_data, in_valid, branch_ack,
    input  ack, dmem_addr, dmem_wdata, dmem_we, out_data, out_valid,
           in_ready, branch_pc, branch_valid, error
  );

endinterface

// File: rtl/bf_exec_ctrl_loop_stack.sv
// LIFO of loop-start PCs. Push/pop take effect on the next edge; the top
// entry is read combinationally from sp-1. A push while full or a pop while
// empty is ignored here; the controller turns those into a fault.
module bf_loop_stack #(
  parameter int PC_W        = 12,
  parameter int STACK_DEPTH = 16
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic [PC_W-1:0] i_din,
  output logic [PC_W-1:0] o_top,
  output logic            o_empty,
  output logic            o_full
);

  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam logic [IDX_W:0] SP_FULL = (IDX_W+1)'(STACK_DEPTH);

  logic [IDX_W:0]   r_sp;
  logic [PC_W-1:0]  r_mem [STACK_DEPTH];
  logic [IDX_W-1:0] w_top_idx;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_sp == {(IDX_W+1){1'b0}});
  assign o_full    = (r_sp == SP_FULL);
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~i_push & ~o_empty;
  assign w_top_idx = r_sp[IDX_W-1:0] - IDX_W'(1);
  assign o_top     = r_mem[w_top_idx];

  // stack pointer: push has priority, reset empties the stack
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sp <= {(IDX_W+1){1'b0}};
    end else if (w_do_push) begin
      r_sp <= r_sp + (IDX_W+1)'(1);
    end else if (w_do_pop) begin
      r_sp <= r_sp - (IDX_W+1)'(1);
    end else begin
      r_sp <= r_sp;
    end
  end

  // entry storage: written at the current sp on push, never cleared
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_sp[IDX_W-1:0]] <= i_din;
    end
  end

endmodule

// File: rtl/bf_exec_ctrl.sv
// Execute stage of the pipelined BF CPU. Owns the data pointer and a cached
// copy of the current cell, sequences memory reload on pointer moves, the
// output/input handshakes, bracket skipping and backward branches to fetch.
module bf_exec_ctrl
  import bf_exec_ctrl_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 15,
  parameter int PC_W        = 12,
  parameter int STACK_DEPTH = 16
) (
  input  logic           i_clk,
  input  logic           i_reset,
  bf_exec_ctrl_if.master io_ctrl
);

  // skip depth can never exceed the number of brackets in the program
  localparam int DEPTH_W = PC_W + 1;

  logic [2:0]         r_state;
  logic [ADDR_W-1:0]  r_ptr;
  logic [DATA_W-1:0]  r_cell;
  logic [DEPTH_W-1:0] r_depth;
  logic               r_ack;
  logic               r_out_valid;
  logic [DATA_W-1:0]  r_out_data;
  logic               r_in_ready;
  logic               r_branch_valid;
  logic [PC_W-1:0]    r_branch_pc;
  logic               r_error;

  op_dec_t            w_dec;
  logic               w_accept;
  logic               w_exec_acc;
  logic               w_cell_zero;
  logic               w_push;
  logic               w_pop;
  logic [PC_W-1:0]    w_stk_top;
  logic               w_stk_empty;
  logic               w_stk_full;

  assign w_dec       = decode_op(io_ctrl.operation);
  // ack=0 keeps an op that upstream is still holding from being taken twice
  assign w_accept    = ((r_state == ST_EXEC) || (r_state == ST_SKIP) ||
                        (r_state == ST_BRANCH)) &&
                       io_ctrl.drdy_in && !r_ack;
  assign w_exec_acc  = w_accept && (r_state == ST_EXEC);
  assign w_cell_zero = (r_cell == {DATA_W{1'b0}});
  assign w_push      = w_exec_acc && w_dec.lbeg && !w_cell_zero && !w_stk_full;
  assign w_pop       = w_exec_acc && w_dec.lend && w_cell_zero && !w_stk_empty;

  bf_loop_stack #(
    .PC_W        (PC_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_loop_stack (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (io_ctrl.op_pc),
    .o_top   (w_stk_top),
    .o_empty (w_stk_empty),
    .o_full  (w_stk_full)
  );

  // the cached cell is written back in the same cycle a move is accepted;
  // the address then follows the updated pointer for the reload read
  assign io_ctrl.dmem_addr    = r_ptr;
  assign io_ctrl.dmem_wdata   = r_cell;
  assign io_ctrl.dmem_we      = w_exec_acc && (w_dec.right || w_dec.left);
  assign io_ctrl.ack          = r_ack;
  assign io_ctrl.out_data     = r_out_data;
  assign io_ctrl.out_valid    = r_out_valid;
  assign io_ctrl.in_ready     = r_in_ready;
  assign io_ctrl.branch_pc    = r_branch_pc;
  assign io_ctrl.branch_valid = r_branch_valid;
  assign io_ctrl.error        = r_error;

  // execute FSM, datapath registers and registered handshake outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= ST_EXEC;
      r_ptr          <= {ADDR_W{1'b0}};
      r_cell         <= {DATA_W{1'b0}};
      r_depth        <= {DEPTH_W{1'b0}};
      r_ack          <= 1'b0;
      r_out_valid    <= 1'b0;
      r_out_data     <= {DATA_W{1'b0}};
      r_in_ready     <= 1'b0;
      r_branch_valid <= 1'b0;
      r_branch_pc    <= {PC_W{1'b0}};
      r_error        <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        ST_EXEC: begin
          if (w_accept) begin
            if (w_dec.inc) begin
              r_cell <= r_cell + DATA_W'(1);
              r_ack  <= 1'b1;
            end else if (w_dec.dec) begin
              r_cell <= r_cell - DATA_W'(1);
              r_ack  <= 1'b1;
            end else if (w_dec.right) begin
              r_ptr   <= r_ptr + ADDR_W'(1);
              r_state <= ST_FETCH;
            end else if (w_dec.left) begin
              r_ptr   <= r_ptr - ADDR_W'(1);
              r_state <= ST_FETCH;
            end else if (w_dec.put) begin
              r_out_valid <= 1'b1;
              r_out_data  <= r_cell;
              r_state     <= ST_OUT;
            end else if (w_dec.get) begin
              r_in_ready <= 1'b1;
              r_state    <= ST_IN;
            end else if (w_dec.lbeg) begin
              if (w_cell_zero) begin
                r_depth <= DEPTH_W'(1);
                r_ack   <= 1'b1;
                r_state <= ST_SKIP;
              end else if (w_stk_full) begin
                r_error <= 1'b1;
                r_state <= ST_HALT;
              end else begin
                r_ack <= 1'b1;
              end
            end else if (w_dec.lend) begin
              if (w_stk_empty) begin
                r_error <= 1'b1;
                r_state <= ST_HALT;
              end else if (w_cell_zero) begin
                r_ack <= 1'b1;
              end else begin
                r_branch_pc    <= w_stk_top + PC_W'(1);
                r_branch_valid <= 1'b1;
                r_ack          <= 1'b1;
                r_state        <= ST_BRANCH;
              end
            end else begin
              r_ack <= 1'b1;
            end
          end
        end
        ST_FETCH: begin
          r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          r_cell  <= io_ctrl.dmem_rdata;
          r_ack   <= 1'b1;
          r_state <= ST_EXEC;
        end
        ST_OUT: begin
          if (io_ctrl.out_ready) begin
            r_out_valid <= 1'b0;
            r_ack       <= 1'b1;
            r_state     <= ST_EXEC;
          end
        end
        ST_IN: begin
          if (io_ctrl.in_valid) begin
            r_cell     <= io_ctrl.in_data;
            r_in_ready <= 1'b0;
            r_ack      <= 1'b1;
            r_state    <= ST_EXEC;
          end
        end
        ST_SKIP: begin
          if (w_accept) begin
            r_ack <= 1'b1;
            if (w_dec.lbeg) begin
              r_depth <= r_depth + DEPTH_W'(1);
            end else if (w_dec.lend) begin
              r_depth <= r_depth - DEPTH_W'(1);
              if (r_depth == DEPTH_W'(1)) begin
                r_state <= ST_EXEC;
              end
            end
          end
        end
        ST_BRANCH: begin
          // ops arriving here are pre-redirect leftovers: ack and drop
          if (w_accept) begin
            r_ack <= 1'b1;
          end
          if (io_ctrl.branch_ack) begin
            r_branch_valid <= 1'b0;
            r_state        <= ST_EXEC;
          end
        end
        ST_HALT: begin
          r_error <= 1'b1;
        end
        default: begin
          r_error <= 1'b1;
          r_state <= ST_HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bf_exec_ctrl.sv
// Self-checking bench for bf_exec_ctrl: table of single-op vectors with
// expected ack latency, scoreboards for output bytes and memory writes,
// and hand-written sequences for input wait, output stall, skip, branch
// and stack overflow.
module tb_bf_exec_ctrl;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 15;
  localparam int PC_W   = 12;
  localparam int DEPTH  = 16;

  localparam logic [7:0] O_R = 8'h01;
  localparam logic [7:0] O_L = 8'h02;
  localparam logic [7:0] O_P = 8'h04;
  localparam logic [7:0] O_M = 8'h08;
  localparam logic [7:0] O_O = 8'h10;
  localparam logic [7:0] O_I = 8'h20;
  localparam logic [7:0] O_B = 8'h40;
  localparam logic [7:0] O_E = 8'h80;

  logic clk;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;

  logic [7:0]  mem [32768];
  logic [7:0]  exp_out_q [$];
  logic [22:0] exp_wr_q  [$];

  typedef struct {
    bit          do_reset;
    logic [7:0]  op;
    logic [11:0] pc;
    int          exp_lat;
    bit          has_out;
    logic [7:0]  out_b;
    bit          has_wr;
    logic [22:0] wr;
  } vec_t;

  vec_t vecs [$];

  bf_exec_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_W(PC_W)) bus ();

  bf_exec_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_W(PC_W), .STACK_DEPTH(DEPTH)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .io_ctrl (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous-read data memory model
  always @(posedge clk) begin
    if (bus.dmem_we) mem[bus.dmem_addr] <= bus.dmem_wdata;
    bus.dmem_rdata <= mem[bus.dmem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  // scoreboard: output bytes and memory writes popped as the DUT produces them
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_out_q.size() == 0) check("out_unexpected", 32'd1, 32'd0);
        else check("out_data", {24'd0, bus.out_data}, {24'd0, exp_out_q.pop_front()});
      end
      if (bus.dmem_we) begin
        if (exp_wr_q.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
        else check("dmem_write", {9'd0, bus.dmem_addr, bus.dmem_wdata}, {9'd0, exp_wr_q.pop_front()});
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.drdy_in = 1'b0; bus.operation = 8'h00; bus.in_valid = 1'b0;
    bus.branch_ack = 1'b0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // cycles from the drive cycle to the ack cycle; -1 if no ack within budget
  task automatic wait_ack(input int budget, output int lat);
    lat = 0;
    @(negedge clk);
    while (!bus.ack && lat < budget) begin
      lat++;
      @(negedge clk);
    end
    if (!bus.ack) lat = -1;
  endtask

  task automatic send_op(input logic [7:0] op, input logic [11:0] pc, output int lat);
    @(posedge clk); #1;
    bus.operation = op; bus.op_pc = pc; bus.drdy_in = 1'b1;
    wait_ack(12, lat);
    @(posedge clk); #1;
    bus.drdy_in = 1'b0;
    @(negedge clk);
    check("ack_one_cycle", {31'd0, bus.ack}, 32'd0);
  endtask

  task automatic op_chk(input string name, input logic [7:0] op, input logic [11:0] pc, input int exp_lat);
    int lat;
    send_op(op, pc, lat);
    check(name, lat, exp_lat);
  endtask

  task automatic add_vec(input bit r, input logic [7:0] op, input int lat,
                         input bit ho, input logic [7:0] ob, input bit hw, input logic [22:0] wr);
    vec_t v;
    v.do_reset = r; v.op = op; v.pc = 12'd0; v.exp_lat = lat;
    v.has_out = ho; v.out_b = ob; v.has_wr = hw; v.wr = wr;
    vecs.push_back(v);
  endtask

  initial begin
    int lat, cnt, acks;
    rst = 1'b1;
    bus.operation = 8'h00; bus.op_pc = 12'd0; bus.drdy_in = 1'b0;
    bus.out_ready = 1'b1; bus.in_data = 8'h00; bus.in_valid = 1'b0; bus.branch_ack = 1'b0;
    for (int i = 0; i < 32768; i++) mem[i] <= 8'h00;
    mem[15'h7FFF] <= 8'h5A;

    // ---- vector table: {reset, op, ack latency, output, memory write}
    add_vec(1, O_P, 1, 0, 8'h00, 0, 23'h0);
    add_vec(0, O_P, 1, 0, 8'h00, 0, 23'h0);
    add_vec(0, O_P, 1, 0, 8'h00, 0, 23'h0);
    add_vec(0, O_O, 2, 1, 8'h03, 0, 23'h0);
    for (int i = 0; i < 4; i++) add_vec(0, O_M, 1, 0, 8'h00, 0, 23'h0);
    add_vec(0, O_O, 2, 1, 8'hFF, 0, 23'h0);
    add_vec(0, O_L, 3, 0, 8'h00, 1, {15'h0000, 8'hFF});
    add_vec(0, O_O, 2, 1, 8'h5A, 0, 23'h0);
    add_vec(0, O_R, 3, 0, 8'h00, 1, {15'h7FFF, 8'h5A});
    add_vec(0, O_O, 2, 1, 8'hFF, 0, 23'h0);
    add_vec(0, 8'h03, 1, 0, 8'h00, 0, 23'h0);
    add_vec(0, 8'h00, 1, 0, 8'h00, 0, 23'h0);
    add_vec(0, O_O, 2, 1, 8'hFF, 0, 23'h0);
    add_vec(1, O_M, 1, 0, 8'h00, 0, 23'h0);
    add_vec(0, O_O, 2, 1, 8'hFF, 0, 23'h0);
    add_vec(0, O_L, 3, 0, 8'h00, 1, {15'h0000, 8'hFF});
    add_vec(0, O_O, 2, 1, 8'h5A, 0, 23'h0);
    add_vec(1, O_P, 1, 0, 8'h00, 0, 23'h0);
    for (int i = 0; i < 4; i++) add_vec(0, O_P, 1, 0, 8'h00, 0, 23'h0);
    add_vec(0, O_R, 3, 0, 8'h00, 1, {15'h0000, 8'h05});
    add_vec(0, O_P, 1, 0, 8'h00, 0, 23'h0);
    add_vec(0, O_L, 3, 0, 8'h00, 1, {15'h0001, 8'h01});
    add_vec(0, O_O, 2, 1, 8'h05, 0, 23'h0);

    // ---- reset values
    apply_reset();
    @(negedge clk);
    check("rst_ack", {31'd0, bus.ack}, 32'd0);
    check("rst_dmem_we", {31'd0, bus.dmem_we}, 32'd0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("rst_branch_valid", {31'd0, bus.branch_valid}, 32'd0);
    check("rst_error", {31'd0, bus.error}, 32'd0);
    check("rst_dmem_addr", {17'd0, bus.dmem_addr}, 32'd0);

    // ---- table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].do_reset) apply_reset();
      if (vecs[i].has_out) exp_out_q.push_back(vecs[i].out_b);
      if (vecs[i].has_wr) exp_wr_q.push_back(vecs[i].wr);
      send_op(vecs[i].op, vecs[i].pc, lat);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
    end

    // ---- input with in_valid delayed 4 cycles
    apply_reset();
    @(posedge clk); #1;
    bus.operation = O_I; bus.drdy_in = 1'b1;
    @(negedge clk);
    cnt = 0; acks = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.in_ready) cnt++;
      if (bus.ack) acks++;
    end
    check("in_ready_wait_cycles", cnt, 4);
    check("in_no_ack_while_waiting", acks, 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_data = 8'h41;
    wait_ack(12, lat);
    check("in_ack_latency", lat, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.drdy_in = 1'b0;
    @(negedge clk);
    check("in_ready_dropped", {31'd0, bus.in_ready}, 32'd0);
    exp_out_q.push_back(8'h41);
    op_chk("in_echo_lat", O_O, 12'd0, 2);

    // ---- reset while waiting for input aborts the wait
    @(posedge clk); #1;
    bus.operation = O_I; bus.drdy_in = 1'b1;
    repeat (3) @(negedge clk);
    check("in_ready_before_abort", {31'd0, bus.in_ready}, 32'd1);
    apply_reset();
    @(negedge clk);
    check("in_ready_after_abort", {31'd0, bus.in_ready}, 32'd0);
    op_chk("post_abort_inc", O_P, 12'd0, 1);

    // ---- output stalled 3 cycles by out_ready
    bus.out_ready = 1'b0;
    exp_out_q.push_back(8'h01);
    @(posedge clk); #1;
    bus.operation = O_O; bus.drdy_in = 1'b1;
    @(negedge clk);
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_data == 8'h01 && !bus.ack) cnt++;
    end
    check("out_held_stable", cnt, 3);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_ack(12, lat);
    check("out_stall_ack_lat", lat, 1);
    @(posedge clk); #1;
    bus.drdy_in = 1'b0;

    // ---- forward skip over a nested loop
    apply_reset();
    op_chk("skip_enter", O_B, 12'd10, 1);
    op_chk("skip_lbeg", O_B, 12'd11, 1);
    op_chk("skip_inc", O_P, 12'd12, 1);
    op_chk("skip_lend_inner", O_E, 12'd13, 1);
    op_chk("skip_lend_outer", O_E, 12'd14, 1);
    exp_out_q.push_back(8'h00);
    op_chk("skip_out_lat", O_O, 12'd15, 2);
    op_chk("skip_stack_untouched", O_E, 12'd16, -1);
    check("underflow_error", {31'd0, bus.error}, 32'd1);

    // ---- backward branch
    apply_reset();
    op_chk("br_inc1", O_P, 12'd1, 1);
    op_chk("br_inc2", O_P, 12'd2, 1);
    op_chk("br_push", O_B, 12'd4, 1);
    op_chk("br_dec", O_M, 12'd5, 1);
    op_chk("br_lend", O_E, 12'd6, 1);
    check("branch_valid", {31'd0, bus.branch_valid}, 32'd1);
    check("branch_pc", {20'd0, bus.branch_pc}, 32'd5);
    op_chk("br_stale_inc", O_P, 12'd7, 1);
    op_chk("br_stale_out", O_O, 12'd8, 1);
    check("branch_valid_held", {31'd0, bus.branch_valid}, 32'd1);
    @(posedge clk); #1 bus.branch_ack = 1'b1;
    @(posedge clk); #1 bus.branch_ack = 1'b0;
    @(negedge clk);
    check("branch_valid_cleared", {31'd0, bus.branch_valid}, 32'd0);
    op_chk("br_target_dec", O_M, 12'd5, 1);
    op_chk("br_pop", O_E, 12'd6, 1);
    exp_out_q.push_back(8'h00);
    op_chk("br_out_lat", O_O, 12'd7, 2);
    op_chk("br_inc3", O_P, 12'd8, 1);
    op_chk("br_stack_empty", O_E, 12'd9, -1);
    check("br_empty_error", {31'd0, bus.error}, 32'd1);

    // ---- stack overflow on the 17th nested push
    apply_reset();
    @(negedge clk);
    check("error_cleared_by_reset", {31'd0, bus.error}, 32'd0);
    op_chk("ovf_inc", O_P, 12'd0, 1);
    cnt = 0;
    for (int i = 0; i < DEPTH; i++) begin
      send_op(O_B, 12'(i + 1), lat);
      if (lat == 1) cnt++;
    end
    check("ovf_pushes_acked", cnt, DEPTH);
    check("ovf_no_error_yet", {31'd0, bus.error}, 32'd0);
    op_chk("ovf_17th_push", O_B, 12'd17, -1);
    check("ovf_error", {31'd0, bus.error}, 32'd1);
    op_chk("halt_no_ack", O_R, 12'd18, -1);
    check("halt_error_sticky", {31'd0, bus.error}, 32'd1);

    check("out_queue_drained", exp_out_q.size(), 0);
    check("wr_queue_drained", exp_wr_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
